nfc_seq: RTL and testbench
==========================

NFC_SEQ -- requirements
Module: nfc_seq

Interface
REQ-001 Parameter TMO_CYC, default 16'hFFFF: max cycles spent in WAIT_RB before timeout.
REQ-002 Parameter TWB_CYC, default 4: cycles ignored after a busy-causing command before nf_rb is sampled.
REQ-003 clk  in  1  sole clock; all logic rises on posedge clk.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 op_start  in  1  one-cycle request pulse; accepted only in IDLE.
REQ-006 op_code  in  2  00 page read, 01 page program, 10 read status, 11 block erase.
REQ-007 op_row_addr/op_col_addr  in  32/32  target address, captured on accept.
REQ-008 op_addr_cnt  in  6  address-cycle config, captured on accept, forwarded unchanged.
REQ-009 op_dat_cnt  in  14  data byte count for read/program, captured on accept.
REQ-010 nf_rb  in  1  flash ready/busy pin, 1 = ready.
REQ-011 nfc_cmd_en/nfc_addr_en/nfc_dat_en  out  1  one-cycle phase-start pulses to the interface block.
REQ-012 nfc_if_cmd  out  8 | nfc_col_addr, nfc_row_addr  out  32 | nfc_addr_cnt  out  6 | nfc_dat_cnt  out  14 | nfc_dat_dir  out  1 (1 write, 0 read).
REQ-013 nfif_cmd_done/nfif_addr_done/nfif_dat_done  in  1  phase-completion pulses.
REQ-014 nfif_data_wr  in  1, nfif_data_out  in  8  read byte strobe and data.
REQ-015 seq_busy  out  1 | seq_done  out  1 pulse | seq_err  out  1 pulse | seq_status  out  8  last status byte.

Function
REQ-016 States: IDLE, CMD1, ADDR, CMD2, WAIT_RB, DATA, STAT_CMD, STAT_DAT, FIN.
REQ-017 On each issue state, assert the matching *_en for exactly one cycle at the entry cycle, then hold the state until the matching done pulse; done arriving in the entry cycle is honoured.
REQ-018 Read (00): CMD1 0x00 -> ADDR -> CMD2 0x30 -> WAIT_RB -> DATA (dir 0, cnt op_dat_cnt) -> FIN.
REQ-019 Program (01): CMD1 0x80 -> ADDR -> DATA (dir 1) -> CMD2 0x10 -> WAIT_RB -> STAT_CMD 0x70 -> STAT_DAT -> FIN.
REQ-020 Status (10): STAT_CMD 0x70 -> STAT_DAT -> FIN.
REQ-021 Erase (11): CMD1 0x60 -> ADDR (nfc_col_addr driven 0) -> CMD2 0xD0 -> WAIT_RB -> STAT_CMD -> STAT_DAT -> FIN.
REQ-022 STAT_DAT: nfc_dat_dir=0, nfc_dat_cnt=1; first nfif_data_wr byte loads seq_status.
REQ-023 WAIT_RB: counter cleared on entry; nf_rb ignored for TWB_CYC cycles, then exit when nf_rb=1 sampled.
REQ-024 WAIT_RB timeout: counter reaching TMO_CYC with nf_rb=0 -> FIN with error; counter saturates, never wraps.
REQ-025 FIN lasts one cycle: seq_done=1; seq_err=1 if timeout, or if program/erase and seq_status[0]=1.
REQ-026 Status op (10) never sets seq_err from seq_status[0].
REQ-027 seq_busy=1 in every state except IDLE; op_start while busy is ignored, no queueing.
REQ-028 Operand outputs held stable from accept until return to IDLE.
REQ-029 Unexpected done pulses (wrong phase, or in IDLE) are ignored.
REQ-030 Latency accept->CMD1 pulse: 1 cycle (op_start at cycle N, nfc_cmd_en at N+1).

Reset
REQ-031 rst=1 immediately forces IDLE, all pulses/en 0, seq_busy 0, seq_status 8'h00, counters 0, captured operands 0, nfc_dat_dir 0.
REQ-032 rst mid-operation aborts without seq_done/seq_err; first op_start after release is accepted normally.

Verification
REQ-033 Status op, interface model returns 8'hE0 -> nfc_if_cmd 0x70, cnt 1, seq_status 8'hE0, seq_done pulse, seq_err 0.
REQ-034 Page read row 0x00012345, col 0, cnt 16, nf_rb low 50 cycles -> command sequence 0x00,addr,0x30, dat_en after nf_rb rises, seq_done, no err.
REQ-035 Program cnt 16, status returns 8'h01 -> 0x80,addr,data dir 1,0x10,0x70; seq_err and seq_done pulse same cycle.
REQ-036 Erase with TMO_CYC=100, nf_rb stuck 0 -> FIN after ~100 cycles in WAIT_RB, seq_err=1, no STAT_CMD issued.
REQ-037 op_start during busy plus stray nfif_addr_done in DATA -> both ignored, original op completes unchanged.
REQ-038 rst asserted in DATA of a read -> outputs reset same cycle, no seq_done; next status op completes normally.

Source files
------------

// File: rtl/nfc_seq.sv
// NAND flash operation sequencer: turns one accepted op request into the
// command/address/data phase pulses for the flash interface block, then reports done/error.
module nfc_seq #(
    parameter int unsigned TMO_CYC = 16'hFFFF,
    parameter int unsigned TWB_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_start,
    input  logic [1:0]  op_code,
    input  logic [31:0] op_row_addr,
    input  logic [31:0] op_col_addr,
    input  logic [5:0]  op_addr_cnt,
    input  logic [13:0] op_dat_cnt,
    input  logic        nf_rb,
    output logic        nfc_cmd_en,
    output logic        nfc_addr_en,
    output logic        nfc_dat_en,
    output logic [7:0]  nfc_if_cmd,
    output logic [31:0] nfc_col_addr,
    output logic [31:0] nfc_row_addr,
    output logic [5:0]  nfc_addr_cnt,
    output logic [13:0] nfc_dat_cnt,
    output logic        nfc_dat_dir,
    input  logic        nfif_cmd_done,
    input  logic        nfif_addr_done,
    input  logic        nfif_dat_done,
    input  logic        nfif_data_wr,
    input  logic [7:0]  nfif_data_out,
    output logic        seq_busy,
    output logic        seq_done,
    output logic        seq_err,
    output logic [7:0]  seq_status,
    output logic [3:0]  o_dbg_state
);

    // Phase handshake: a *_en pulse is issued on the first cycle of a phase state;
    // the state is held until the matching *_done pulse, which may arrive on that same cycle.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_CMD1     = 4'd1,
        S_ADDR     = 4'd2,
        S_CMD2     = 4'd3,
        S_WAIT_RB  = 4'd4,
        S_DATA     = 4'd5,
        S_STAT_CMD = 4'd6,
        S_STAT_DAT = 4'd7,
        S_FIN      = 4'd8
    } state_t;

    localparam logic [1:0]  OP_READ  = 2'b00;
    localparam logic [1:0]  OP_PROG  = 2'b01;
    localparam logic [1:0]  OP_STAT  = 2'b10;
    localparam logic [1:0]  OP_ERASE = 2'b11;
    localparam logic [15:0] TMO_LIM  = 16'(TMO_CYC);
    localparam logic [15:0] TWB_LIM  = 16'(TWB_CYC);

    state_t      r_state;
    state_t      w_next;
    logic        r_first;
    logic [1:0]  r_op;
    logic [31:0] r_row;
    logic [31:0] r_col;
    logic [5:0]  r_acnt;
    logic [13:0] r_dcnt;
    logic [15:0] r_cnt;
    logic        r_tmo;
    logic [7:0]  r_status;
    logic        r_stat_got;
    logic        w_rb_ok;
    logic        w_tmo_hit;

    // nf_rb is meaningless during tWB, so it only counts once the window has elapsed
    assign w_rb_ok   = (r_cnt >= TWB_LIM) && nf_rb;
    assign w_tmo_hit = (r_cnt >= TMO_LIM);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (op_start) w_next = (op_code == OP_STAT) ? S_STAT_CMD : S_CMD1;
            S_CMD1:     if (nfif_cmd_done) w_next = S_ADDR;
            S_ADDR:     if (nfif_addr_done) w_next = (r_op == OP_PROG) ? S_DATA : S_CMD2;
            S_CMD2:     if (nfif_cmd_done) w_next = S_WAIT_RB;
            S_WAIT_RB: begin
                if (w_rb_ok)        w_next = (r_op == OP_READ) ? S_DATA : S_STAT_CMD;
                else if (w_tmo_hit) w_next = S_FIN;
            end
            S_DATA:     if (nfif_dat_done) w_next = (r_op == OP_PROG) ? S_CMD2 : S_FIN;
            S_STAT_CMD: if (nfif_cmd_done) w_next = S_STAT_DAT;
            S_STAT_DAT: if (nfif_dat_done) w_next = S_FIN;
            S_FIN:      w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        nfc_cmd_en  = 1'b0;
        nfc_addr_en = 1'b0;
        nfc_dat_en  = 1'b0;
        nfc_if_cmd  = 8'h00;
        nfc_dat_dir = 1'b0;
        nfc_dat_cnt = r_dcnt;
        seq_done    = 1'b0;
        seq_err     = 1'b0;
        case (r_state)
            S_CMD1: begin
                nfc_cmd_en = r_first;
                nfc_if_cmd = (r_op == OP_PROG) ? 8'h80 : (r_op == OP_ERASE) ? 8'h60 : 8'h00;
            end
            S_ADDR: nfc_addr_en = r_first;
            S_CMD2: begin
                nfc_cmd_en = r_first;
                nfc_if_cmd = (r_op == OP_PROG) ? 8'h10 : (r_op == OP_ERASE) ? 8'hD0 : 8'h30;
            end
            S_DATA: begin
                nfc_dat_en  = r_first;
                nfc_dat_dir = (r_op == OP_PROG);
            end
            S_STAT_CMD: begin
                nfc_cmd_en = r_first;
                nfc_if_cmd = 8'h70;
            end
            S_STAT_DAT: begin
                nfc_dat_en  = r_first;
                nfc_dat_cnt = 14'd1;
            end
            S_FIN: begin
                seq_done = 1'b1;
                // a plain status read reports the byte but never flags it as a failure
                seq_err  = r_tmo || (((r_op == OP_PROG) || (r_op == OP_ERASE)) && r_status[0]);
            end
            default: ;
        endcase
    end

    assign seq_busy     = (r_state != S_IDLE);
    assign seq_status   = r_status;
    assign nfc_row_addr = r_row;
    assign nfc_col_addr = (r_op == OP_ERASE) ? 32'h0 : r_col;
    assign nfc_addr_cnt = r_acnt;
    assign o_dbg_state  = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_first    <= 1'b0;
            r_op       <= 2'b00;
            r_row      <= 32'h0;
            r_col      <= 32'h0;
            r_acnt     <= 6'h0;
            r_dcnt     <= 14'h0;
            r_cnt      <= 16'h0;
            r_tmo      <= 1'b0;
            r_status   <= 8'h00;
            r_stat_got <= 1'b0;
        end else begin
            r_state <= w_next;
            r_first <= (w_next != r_state);
            if ((r_state == S_IDLE) && op_start) begin
                r_op   <= op_code;
                r_row  <= op_row_addr;
                r_col  <= op_col_addr;
                r_acnt <= op_addr_cnt;
                r_dcnt <= op_dat_cnt;
                r_tmo  <= 1'b0;
            end
            if ((w_next == S_WAIT_RB) && (r_state != S_WAIT_RB)) begin
                r_cnt <= 16'h0;
            end else if ((r_state == S_WAIT_RB) && (r_cnt < TMO_LIM)) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if ((r_state == S_WAIT_RB) && (w_next == S_FIN)) begin
                r_tmo <= 1'b1;
            end
            // only the first byte of the status phase is the status register
            if ((w_next == S_STAT_DAT) && (r_state != S_STAT_DAT)) begin
                r_stat_got <= 1'b0;
            end else if ((r_state == S_STAT_DAT) && nfif_data_wr && !r_stat_got) begin
                r_status   <= nfif_data_out;
                r_stat_got <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nfc_seq.sv
// Self-checking bench for nfc_seq: a flash-interface responder records every phase
// pulse, and each test compares that record with an op-level expected phase list.
module tb_nfc_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_start = 1'b0;
    logic [1:0]  op_code = 2'b00;
    logic [31:0] op_row_addr = 32'h0;
    logic [31:0] op_col_addr = 32'h0;
    logic [5:0]  op_addr_cnt = 6'h0;
    logic [13:0] op_dat_cnt = 14'h0;
    logic        nf_rb = 1'b1;
    logic        nfc_cmd_en, nfc_addr_en, nfc_dat_en, nfc_dat_dir;
    logic [7:0]  nfc_if_cmd;
    logic [31:0] nfc_col_addr, nfc_row_addr;
    logic [5:0]  nfc_addr_cnt;
    logic [13:0] nfc_dat_cnt;
    logic        nfif_cmd_done = 1'b0;
    logic        nfif_addr_done = 1'b0;
    logic        nfif_dat_done = 1'b0;
    logic        nfif_data_wr = 1'b0;
    logic [7:0]  nfif_data_out = 8'h00;
    logic        seq_busy, seq_done, seq_err;
    logic [7:0]  seq_status;
    logic [3:0]  o_dbg_state;

    nfc_seq #(.TMO_CYC(100), .TWB_CYC(4)) dut (
        .clk(clk), .rst(rst), .op_start(op_start), .op_code(op_code),
        .op_row_addr(op_row_addr), .op_col_addr(op_col_addr),
        .op_addr_cnt(op_addr_cnt), .op_dat_cnt(op_dat_cnt), .nf_rb(nf_rb),
        .nfc_cmd_en(nfc_cmd_en), .nfc_addr_en(nfc_addr_en), .nfc_dat_en(nfc_dat_en),
        .nfc_if_cmd(nfc_if_cmd), .nfc_col_addr(nfc_col_addr), .nfc_row_addr(nfc_row_addr),
        .nfc_addr_cnt(nfc_addr_cnt), .nfc_dat_cnt(nfc_dat_cnt), .nfc_dat_dir(nfc_dat_dir),
        .nfif_cmd_done(nfif_cmd_done), .nfif_addr_done(nfif_addr_done),
        .nfif_dat_done(nfif_dat_done), .nfif_data_wr(nfif_data_wr),
        .nfif_data_out(nfif_data_out), .seq_busy(seq_busy), .seq_done(seq_done),
        .seq_err(seq_err), .seq_status(seq_status), .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int npass = 0;

    // responder-owned state
    logic [31:0] obs_q[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          err_only_cnt = 0;
    logic        err_at_done = 1'b0;
    int          t_cmd2 = 0;
    int          t_done = 0;
    logic [31:0] obs_row = 32'h0;
    logic [31:0] obs_col = 32'h0;
    logic [5:0]  obs_acnt = 6'h0;
    logic        rb_at_dat = 1'b0;
    logic [7:0]  last_cmd = 8'h00;
    bit          pend_c = 0, pend_a = 0, pend_d = 0, d_is_stat = 0;
    int          dly_c = 0, dly_a = 0, dly_d = 0, rb_cnt = 0;
    int          stray_served = 0;

    // test-owned knobs and model state
    logic [31:0] exp_q[$];
    int          rb_low = 0;
    bit          rb_stuck = 0;
    bit          hold_dat = 0;
    bit          stray_data = 0;
    int          stray_req = 0;
    logic [7:0]  resp_status = 8'h00;
    logic [7:0]  model_status = 8'h00;
    int          obs_base = 0;
    int          done_base = 0;
    int          err_base = 0;

    function automatic logic [31:0] ev_cmd(input logic [7:0] c);
        return {4'h1, 20'h0, c};
    endfunction
    function automatic logic [31:0] ev_addr();
        return {4'h2, 28'h0};
    endfunction
    function automatic logic [31:0] ev_dat(input logic dir, input logic [13:0] cnt);
        return {4'h3, 13'h0, dir, cnt};
    endfunction

    // Flash interface model: logs phase pulses, answers each with a done after 0..3 cycles.
    always @(negedge clk) begin
        nfif_cmd_done  = 1'b0;
        nfif_addr_done = 1'b0;
        nfif_dat_done  = 1'b0;
        nfif_data_wr   = 1'b0;
        cyc++;
        if (rst) begin
            pend_c = 0; pend_a = 0; pend_d = 0; rb_cnt = 0;
            if (!rb_stuck) nf_rb = 1'b1;
        end else begin
            if (rb_cnt > 0) rb_cnt--;
            if (rb_cnt == 0 && !rb_stuck) nf_rb = 1'b1;
            if (seq_done) begin
                done_cnt++;
                err_at_done = seq_err;
                t_done = cyc;
            end else if (seq_err) begin
                err_only_cnt++;
            end
            if (nfc_cmd_en) begin
                obs_q.push_back(ev_cmd(nfc_if_cmd));
                last_cmd = nfc_if_cmd;
                obs_row = nfc_row_addr;
                pend_c = 1; dly_c = $urandom_range(0, 2);
                if (nfc_if_cmd inside {8'h30, 8'h10, 8'hD0}) begin
                    t_cmd2 = cyc;
                    if (rb_stuck || rb_low > 0) begin
                        nf_rb = 1'b0;
                        rb_cnt = rb_low;
                    end
                end
            end
            if (nfc_addr_en) begin
                obs_q.push_back(ev_addr());
                obs_row = nfc_row_addr;
                obs_col = nfc_col_addr;
                obs_acnt = nfc_addr_cnt;
                pend_a = 1; dly_a = $urandom_range(0, 2);
            end
            if (nfc_dat_en) begin
                obs_q.push_back(ev_dat(nfc_dat_dir, nfc_dat_cnt));
                obs_row = nfc_row_addr;
                rb_at_dat = nf_rb;
                pend_d = 1; dly_d = $urandom_range(0, 3);
                d_is_stat = (last_cmd == 8'h70);
                if (stray_data) nfif_addr_done = 1'b1;
            end
            if (pend_c) begin
                if (dly_c == 0) begin nfif_cmd_done = 1'b1; pend_c = 0; end
                else dly_c--;
            end
            if (pend_a) begin
                if (dly_a == 0) begin nfif_addr_done = 1'b1; pend_a = 0; end
                else dly_a--;
            end
            if (pend_d && !hold_dat && dly_d == 0) begin
                nfif_dat_done = 1'b1;
                pend_d = 0;
                if (d_is_stat) begin
                    nfif_data_wr  = 1'b1;
                    nfif_data_out = resp_status;
                end
            end else if (pend_d) begin
                if (!hold_dat) dly_d--;
                // read-page bytes stream past; they must not touch the status register
                if (!d_is_stat && $urandom_range(0, 1) == 1) begin
                    nfif_data_wr  = 1'b1;
                    nfif_data_out = 8'($urandom);
                end
            end
            if (stray_req != stray_served && !seq_busy) begin
                nfif_cmd_done  = 1'b1;
                nfif_addr_done = 1'b1;
                nfif_dat_done  = 1'b1;
                stray_served++;
            end
        end
    end

    // Expected phase list of one op, straight from the op definitions.
    task automatic model_build(input logic [1:0] op, input logic [13:0] dcnt, input bit tmo);
        exp_q.delete();
        case (op)
            2'b00: begin
                exp_q.push_back(ev_cmd(8'h00)); exp_q.push_back(ev_addr());
                exp_q.push_back(ev_cmd(8'h30));
                if (!tmo) exp_q.push_back(ev_dat(1'b0, dcnt));
            end
            2'b01: begin
                exp_q.push_back(ev_cmd(8'h80)); exp_q.push_back(ev_addr());
                exp_q.push_back(ev_dat(1'b1, dcnt)); exp_q.push_back(ev_cmd(8'h10));
                if (!tmo) begin exp_q.push_back(ev_cmd(8'h70)); exp_q.push_back(ev_dat(1'b0, 14'd1)); end
            end
            2'b10: begin
                exp_q.push_back(ev_cmd(8'h70)); exp_q.push_back(ev_dat(1'b0, 14'd1));
            end
            default: begin
                exp_q.push_back(ev_cmd(8'h60)); exp_q.push_back(ev_addr());
                exp_q.push_back(ev_cmd(8'hD0));
                if (!tmo) begin exp_q.push_back(ev_cmd(8'h70)); exp_q.push_back(ev_dat(1'b0, 14'd1)); end
            end
        endcase
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] row, input logic [31:0] col,
                          input logic [5:0] acnt, input logic [13:0] dcnt, input bit inject,
                          output bit lat_ok, output bit timed_out);
        int n;
        obs_base  = obs_q.size();
        done_base = done_cnt;
        err_base  = err_only_cnt;
        @(posedge clk); #1;
        op_code = op; op_row_addr = row; op_col_addr = col;
        op_addr_cnt = acnt; op_dat_cnt = dcnt; op_start = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        lat_ok = (nfc_cmd_en === 1'b1) && (seq_busy === 1'b1);
        n = 0;
        while (done_cnt == done_base && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (inject && n == 6) begin
                op_start = 1'b1; op_code = 2'b10; op_row_addr = ~row;
                op_col_addr = ~col; op_dat_cnt = ~dcnt;
            end else begin
                op_start = 1'b0;
            end
        end
        timed_out = (done_cnt == done_base);
        op_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        nchk++;
        if ({seq_busy, seq_done, seq_err, nfc_cmd_en, nfc_addr_en, nfc_dat_en, nfc_dat_dir} !== 7'b0)
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {seq_busy, seq_done, seq_err, nfc_cmd_en, nfc_addr_en, nfc_dat_en, nfc_dat_dir});
        else npass++;
        nchk++;
        if ({nfc_row_addr, nfc_col_addr, nfc_addr_cnt, nfc_dat_cnt} !== 84'h0)
            $display("FAIL reset_operands: got row %h col %h acnt %h dcnt %h want all 0",
                     nfc_row_addr, nfc_col_addr, nfc_addr_cnt, nfc_dat_cnt);
        else npass++;
        nchk++;
        if (seq_status !== 8'h00 || nfc_if_cmd !== 8'h00)
            $display("FAIL reset_status: got status %h cmd %h want 00 00", seq_status, nfc_if_cmd);
        else npass++;
        rst = 1'b0;
    endtask

    task automatic test_status;
        bit lat, tmo, ok;
        resp_status = 8'hE0;
        rb_low = 0;
        run_op(2'b10, 32'h1111_0000, 32'h22, 6'd3, 14'd9, 0, lat, tmo);
        model_build(2'b10, 14'd9, 0);
        model_status = 8'hE0;
        nchk++;
        if (!lat || tmo) $display("FAIL status_latency: got lat %0d tmo %0d want 1 0", lat, tmo);
        else npass++;
        ok = (obs_q.size() - obs_base == exp_q.size());
        for (int i = 0; ok && i < exp_q.size(); i++) if (obs_q[obs_base + i] !== exp_q[i]) ok = 0;
        nchk++;
        if (!ok) $display("FAIL status_seq: got %0d phases want %0d, contents differ", obs_q.size() - obs_base, exp_q.size());
        else npass++;
        nchk++;
        if (done_cnt - done_base != 1 || err_at_done !== 1'b0)
            $display("FAIL status_done: got done %0d err %b want 1 0", done_cnt - done_base, err_at_done);
        else npass++;
        nchk++;
        if (seq_status !== model_status) $display("FAIL status_byte: got %h want %h", seq_status, model_status);
        else npass++;
    endtask

    task automatic test_read;
        bit lat, tmo, ok;
        resp_status = 8'h3C;
        rb_low = 50;
        run_op(2'b00, 32'h0001_2345, 32'h0, 6'd5, 14'd16, 0, lat, tmo);
        model_build(2'b00, 14'd16, 0);
        nchk++;
        if (!lat || tmo) $display("FAIL read_latency: got lat %0d tmo %0d want 1 0", lat, tmo);
        else npass++;
        ok = (obs_q.size() - obs_base == exp_q.size());
        for (int i = 0; ok && i < exp_q.size(); i++) if (obs_q[obs_base + i] !== exp_q[i]) ok = 0;
        nchk++;
        if (!ok) $display("FAIL read_seq: got %0d phases want %0d, contents differ", obs_q.size() - obs_base, exp_q.size());
        else npass++;
        nchk++;
        if (obs_row !== 32'h0001_2345 || obs_col !== 32'h0 || obs_acnt !== 6'd5)
            $display("FAIL read_addr: got row %h col %h acnt %0d want 00012345 0 5", obs_row, obs_col, obs_acnt);
        else npass++;
        nchk++;
        if (rb_at_dat !== 1'b1) $display("FAIL read_rb_wait: got nf_rb %b at data start want 1", rb_at_dat);
        else npass++;
        nchk++;
        if (done_cnt - done_base != 1 || err_at_done !== 1'b0 || seq_status !== model_status)
            $display("FAIL read_done: got done %0d err %b status %h want 1 0 %h",
                     done_cnt - done_base, err_at_done, seq_status, model_status);
        else npass++;
    endtask

    task automatic test_program;
        bit lat, tmo, ok;
        resp_status = 8'h01;
        rb_low = 10;
        run_op(2'b01, 32'h00AB_CDEF, 32'h0000_0100, 6'd5, 14'd16, 0, lat, tmo);
        model_build(2'b01, 14'd16, 0);
        model_status = 8'h01;
        nchk++;
        if (!lat || tmo) $display("FAIL prog_latency: got lat %0d tmo %0d want 1 0", lat, tmo);
        else npass++;
        ok = (obs_q.size() - obs_base == exp_q.size());
        for (int i = 0; ok && i < exp_q.size(); i++) if (obs_q[obs_base + i] !== exp_q[i]) ok = 0;
        nchk++;
        if (!ok) $display("FAIL prog_seq: got %0d phases want %0d, contents differ", obs_q.size() - obs_base, exp_q.size());
        else npass++;
        nchk++;
        if (done_cnt - done_base != 1 || err_at_done !== 1'b1 || err_only_cnt != err_base)
            $display("FAIL prog_err: got done %0d err %b lone_err %0d want 1 1 0",
                     done_cnt - done_base, err_at_done, err_only_cnt - err_base);
        else npass++;
        nchk++;
        if (seq_status !== model_status) $display("FAIL prog_status: got %h want %h", seq_status, model_status);
        else npass++;
    endtask

    task automatic test_erase_timeout;
        bit lat, tmo, ok;
        int dt;
        resp_status = 8'h00;
        rb_low = 0;
        rb_stuck = 1;
        run_op(2'b11, 32'h0000_4400, 32'hDEAD_BEEF, 6'd3, 14'd7, 0, lat, tmo);
        rb_stuck = 0;
        model_build(2'b11, 14'd7, 1);
        ok = (obs_q.size() - obs_base == exp_q.size());
        for (int i = 0; ok && i < exp_q.size(); i++) if (obs_q[obs_base + i] !== exp_q[i]) ok = 0;
        nchk++;
        if (!ok || tmo) $display("FAIL erase_seq: got %0d phases want %0d (stalled %0d)", obs_q.size() - obs_base, exp_q.size(), tmo);
        else npass++;
        nchk++;
        if (obs_col !== 32'h0) $display("FAIL erase_col: got %h want 00000000", obs_col);
        else npass++;
        dt = t_done - t_cmd2;
        nchk++;
        if (dt < 100 || dt > 106) $display("FAIL erase_tmo_time: got %0d cycles want 100..106", dt);
        else npass++;
        nchk++;
        if (done_cnt - done_base != 1 || err_at_done !== 1'b1 || seq_status !== model_status)
            $display("FAIL erase_err: got done %0d err %b status %h want 1 1 %h",
                     done_cnt - done_base, err_at_done, seq_status, model_status);
        else npass++;
    endtask

    task automatic test_busy_ignore;
        bit lat, tmo, ok;
        int sz;
        rb_low = 20;
        stray_data = 1;
        run_op(2'b00, 32'h0077_1234, 32'h0000_0040, 6'd4, 14'd33, 1, lat, tmo);
        stray_data = 0;
        model_build(2'b00, 14'd33, 0);
        ok = (obs_q.size() - obs_base == exp_q.size());
        for (int i = 0; ok && i < exp_q.size(); i++) if (obs_q[obs_base + i] !== exp_q[i]) ok = 0;
        nchk++;
        if (!ok || tmo) $display("FAIL busy_seq: got %0d phases want %0d (stalled %0d)", obs_q.size() - obs_base, exp_q.size(), tmo);
        else npass++;
        nchk++;
        if (obs_row !== 32'h0077_1234 || done_cnt - done_base != 1 || err_at_done !== 1'b0)
            $display("FAIL busy_operands: got row %h done %0d err %b want 00771234 1 0",
                     obs_row, done_cnt - done_base, err_at_done);
        else npass++;
        sz = obs_q.size();
        stray_req++;
        repeat (4) @(posedge clk);
        #1;
        nchk++;
        if (seq_busy !== 1'b0 || obs_q.size() != sz)
            $display("FAIL idle_stray_done: got busy %b new phases %0d want 0 0", seq_busy, obs_q.size() - sz);
        else npass++;
    endtask

    task automatic test_reset_mid_op;
        bit lat, tmo, ok;
        int n;
        rb_low = 5;
        hold_dat = 1;
        obs_base  = obs_q.size();
        done_base = done_cnt;
        @(posedge clk); #1;
        op_code = 2'b00; op_row_addr = 32'hCAFE_0001; op_col_addr = 32'h10;
        op_addr_cnt = 6'd5; op_dat_cnt = 14'd64; op_start = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        n = 0;
        while (obs_q.size() < obs_base + 4 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        nchk++;
        if (obs_q.size() < obs_base + 4) $display("FAIL rst_reach_data: got %0d phases want 4", obs_q.size() - obs_base);
        else npass++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        nchk++;
        if ({seq_busy, seq_done, seq_err, nfc_dat_en, nfc_dat_dir} !== 5'b0 || nfc_row_addr !== 32'h0 ||
            nfc_dat_cnt !== 14'h0 || seq_status !== 8'h00)
            $display("FAIL rst_mid_outputs: got busy %b done %b row %h dcnt %0d status %h want 0 0 0 0 00",
                     seq_busy, seq_done, nfc_row_addr, nfc_dat_cnt, seq_status);
        else npass++;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        hold_dat = 0;
        model_status = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        nchk++;
        if (done_cnt != done_base || seq_busy !== 1'b0)
            $display("FAIL rst_no_done: got done %0d busy %b want 0 0", done_cnt - done_base, seq_busy);
        else npass++;
        resp_status = 8'hE1;
        rb_low = 0;
        run_op(2'b10, 32'h0, 32'h0, 6'd0, 14'd0, 0, lat, tmo);
        model_build(2'b10, 14'd0, 0);
        model_status = 8'hE1;
        ok = (obs_q.size() - obs_base == exp_q.size());
        for (int i = 0; ok && i < exp_q.size(); i++) if (obs_q[obs_base + i] !== exp_q[i]) ok = 0;
        nchk++;
        if (!ok || !lat || tmo) $display("FAIL rst_next_op_seq: got %0d phases lat %0d want %0d 1", obs_q.size() - obs_base, lat, exp_q.size());
        else npass++;
        nchk++;
        if (done_cnt - done_base != 1 || err_at_done !== 1'b0 || seq_status !== model_status)
            $display("FAIL rst_next_op_done: got done %0d err %b status %h want 1 0 %h",
                     done_cnt - done_base, err_at_done, seq_status, model_status);
        else npass++;
    endtask

    task automatic test_random;
        bit lat, tmo, ok, exp_err;
        logic [1:0]  op;
        logic [31:0] row, col;
        logic [13:0] dcnt;
        for (int k = 0; k < 12; k++) begin
            op   = 2'($urandom_range(0, 3));
            row  = $urandom;
            col  = $urandom;
            dcnt = 14'($urandom_range(1, 16383));
            resp_status = 8'($urandom);
            rb_low = $urandom_range(0, 40);
            run_op(op, row, col, 6'($urandom_range(1, 63)), dcnt, 0, lat, tmo);
            model_build(op, dcnt, 0);
            exp_err = ((op == 2'b01) || (op == 2'b11)) && resp_status[0];
            if (op != 2'b00) model_status = resp_status;
            ok = (obs_q.size() - obs_base == exp_q.size());
            for (int i = 0; ok && i < exp_q.size(); i++) if (obs_q[obs_base + i] !== exp_q[i]) ok = 0;
            nchk++;
            if (!ok || !lat || tmo)
                $display("FAIL rand%0d_seq op %0d: got %0d phases lat %0d want %0d 1", k, op, obs_q.size() - obs_base, lat, exp_q.size());
            else npass++;
            nchk++;
            if (op != 2'b10 && (obs_row !== row || obs_col !== ((op == 2'b11) ? 32'h0 : col)))
                $display("FAIL rand%0d_addr op %0d: got row %h col %h want %h %h", k, op, obs_row, obs_col,
                         row, (op == 2'b11) ? 32'h0 : col);
            else npass++;
            nchk++;
            if (done_cnt - done_base != 1 || err_at_done !== exp_err || seq_status !== model_status)
                $display("FAIL rand%0d_done op %0d: got done %0d err %b status %h want 1 %b %h", k, op,
                         done_cnt - done_base, err_at_done, seq_status, exp_err, model_status);
            else npass++;
        end
    endtask

    initial begin
        test_reset;
        test_status;
        test_read;
        test_program;
        test_erase_timeout;
        test_busy_ignore;
        test_reset_mid_op;
        test_random;
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
